tick_scheduler: RTL and testbench

- Shares one prescaler (system clock to base tick) among N_CH periodic requesters, e.g. servo update and SPI poll channels.
- Each channel has a programmable period, in base ticks.
- Channel expiries are queued as pending bits and handed to one consumer (the SPI transaction launcher) through a round-robin arbitrated valid/ready event port.
- Replaces per-function free-running clock dividers with one clock, single-cycle-strobe scheme.

---
 rtl/tick_sched_pkg.sv | 44 ++++
 rtl/tick_prescaler.sv | 28 ++
 rtl/tick_scheduler.sv | 136 +++++++++++++
 tb/tb_tick_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler:
// arbiter state enum, divider calc and round-robin pick.
package tick_sched_pkg;

  typedef enum logic {IDLE, OFFER} state_t;

  localparam int MAX_CH = 8;
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic int calc_div(
    input int clk_hz,
    input int base_hz
  );
    return clk_hz / base_hz;
  endfunction

  // Nearest pending channel at or above ptr, wrapping at n.
  // Scanned high offset to low so the smallest offset wins.
  function automatic pick_t rr_pick(
    input logic [MAX_CH-1:0] pend,
    input logic [IDX_W-1:0]  ptr,
    input int                n
  );
    pick_t r;
    int    j;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i < n) begin
        j = (int'(ptr) + i) % n;
        if (pend[j[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle base_tick enable every DIV clocks.
// Ports: clk, rst_n (async low), base_tick (registered strobe).
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic base_tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] pcnt;
  logic          wrap;

  assign wrap = (pcnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= wrap;
      pcnt      <= wrap ? '0 : pcnt + CW'(1);
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// N_CH periodic channels on one shared base tick, expiries
// queued as pending bits and offered round-robin on evt_*.
// Ports: clk, rst_n, cfg_we/cfg_ch/cfg_period (period write),
// base_tick, evt_valid/evt_ch/evt_ready, overrun, clr_overrun.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int BASE_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int PER_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [PER_W-1:0]        cfg_period,
  output logic                    base_tick,
  output logic                    evt_valid,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  input  logic                    evt_ready,
  output logic [N_CH-1:0]         overrun,
  input  logic                    clr_overrun
);

  localparam int DIV  = calc_div(CLK_HZ, BASE_HZ);
  localparam int CH_W = $clog2(N_CH);

  logic [PER_W-1:0] period [N_CH];
  logic [PER_W-1:0] cnt    [N_CH];
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  expiry;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  acc_hit;
  logic [N_CH-1:0]  ovr_set;

  state_t           state;
  state_t           state_n;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  rr_ptr_n;
  logic [CH_W-1:0]  evt_ch_n;
  logic             evt_valid_n;
  logic             accept;
  pick_t            pick;

  tick_prescaler #(
    .DIV(DIV)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .base_tick(base_tick)
  );

  assign accept = (state == OFFER) && evt_ready;
  assign pick   = rr_pick(MAX_CH'(pending),
                          IDX_W'(rr_ptr), N_CH);

  // An expiry onto an already pending bit is an overrun
  // unless that bit is being accepted or rewritten now.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      wr_hit[k]  = cfg_we && (int'(cfg_ch) == k);
      acc_hit[k] = accept && (int'(evt_ch) == k);
      expiry[k]  = base_tick && (period[k] != '0) &&
                   (cnt[k] == period[k] - PER_W'(1));
      ovr_set[k] = expiry[k] && pending[k] &&
                   !acc_hit[k] && !wr_hit[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        period[k] <= '0;
        cnt[k]    <= '0;
      end
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_hit[k]) begin
          period[k]  <= cfg_period;
          cnt[k]     <= '0;
          pending[k] <= 1'b0;
        end else begin
          if (base_tick && (period[k] != '0))
            cnt[k] <= expiry[k] ? '0 : cnt[k] + PER_W'(1);
          if (expiry[k])
            pending[k] <= 1'b1;
          else if (acc_hit[k])
            pending[k] <= 1'b0;
        end
      end
      overrun <= (clr_overrun ? '0 : overrun) | ovr_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      evt_valid <= evt_valid_n;
      evt_ch    <= evt_ch_n;
    end
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    evt_valid_n = evt_valid;
    evt_ch_n    = evt_ch;
    unique case (state)
      IDLE: begin
        if (pick.found) begin
          state_n     = OFFER;
          evt_valid_n = 1'b1;
          evt_ch_n    = CH_W'(pick.idx);
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_n     = IDLE;
          evt_valid_n = 1'b0;
          rr_ptr_n    = (int'(evt_ch) == N_CH - 1) ?
                        '0 : evt_ch + CH_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler at DIV=10, N_CH=4, PER_W=8.
// Cycle n is the interval after the n-th edge since reset release.
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic       base_tick;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_ready = 1'b0;
  logic [3:0] overrun;
  logic       clr_overrun = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic       e_v;
  logic [1:0] e_ch;
  logic [3:0] e_ov;
  logic       e_bt;

  tick_scheduler #(
    .CLK_HZ (1000),
    .BASE_HZ(100),
    .N_CH   (4),
    .PER_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .base_tick  (base_tick),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ready  (evt_ready),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    cfg_we = 1'b0;
    clr_overrun = 1'b0;
    evt_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wr_cfg(input logic [1:0] ch,
                        input logic [7:0] per);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_period = per;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if ({base_tick, evt_valid, evt_ch, overrun} !== 8'h00) begin
      n_err++;
      $display("FAIL rst_state got=%b/%b/%0d/%b exp=0/0/0/0000",
               base_tick, evt_valid, evt_ch, overrun);
    end
    for (int n = 1; n <= 35; n++) begin
      step();
      e_bt = (n % 10 == 0);
      n_cmp++;
      if (base_tick !== e_bt) begin
        n_err++;
        $display("FAIL t1_tick cyc=%0d got=%b exp=%b",
                 cyc, base_tick, e_bt);
      end
      n_cmp++;
      if (evt_valid !== 1'b0 || overrun !== 4'b0) begin
        n_err++;
        $display("FAIL t1_idle cyc=%0d got=%b/%b exp=0/0000",
                 cyc, evt_valid, overrun);
      end
    end
  endtask

  task automatic test_period3;
    do_reset();
    evt_ready = 1'b1;
    wr_cfg(2'd1, 8'd3);
    for (int n = 2; n <= 95; n++) begin
      step();
      e_v = (n == 32) || (n == 62) || (n == 92);
      n_cmp++;
      if (evt_valid !== e_v || (e_v && evt_ch !== 2'd1)) begin
        n_err++;
        $display("FAIL t2_evt cyc=%0d got=%b/%0d exp=%b/1",
                 cyc, evt_valid, evt_ch, e_v);
      end
    end
  endtask

  task automatic test_round_robin;
    int m;
    do_reset();
    evt_ready = 1'b1;
    wr_cfg(2'd0, 8'd1);
    wr_cfg(2'd2, 8'd1);
    wr_cfg(2'd3, 8'd1);
    for (int n = 4; n <= 40; n++) begin
      step();
      m = n % 10;
      e_v = (n >= 12) && (m == 2 || m == 4 || m == 6);
      e_ch = (m == 2) ? 2'd0 : (m == 4) ? 2'd2 : 2'd3;
      n_cmp++;
      if (evt_valid !== e_v || (e_v && evt_ch !== e_ch)) begin
        n_err++;
        $display("FAIL t3_rr cyc=%0d got=%b/%0d exp=%b/%0d",
                 cyc, evt_valid, evt_ch, e_v, e_ch);
      end
      n_cmp++;
      if (overrun !== 4'b0) begin
        n_err++;
        $display("FAIL t3_ovr cyc=%0d got=%b exp=0000",
                 cyc, overrun);
      end
    end
  endtask

  task automatic test_overrun;
    do_reset();
    wr_cfg(2'd2, 8'd1);
    for (int n = 2; n <= 35; n++) begin
      step();
      e_v = (n >= 12);
      e_ov = (n >= 21) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (evt_valid !== e_v || (e_v && evt_ch !== 2'd2)) begin
        n_err++;
        $display("FAIL t4_hold cyc=%0d got=%b/%0d exp=%b/2",
                 cyc, evt_valid, evt_ch, e_v);
      end
      n_cmp++;
      if (overrun !== e_ov) begin
        n_err++;
        $display("FAIL t4_ovr cyc=%0d got=%b exp=%b",
                 cyc, overrun, e_ov);
      end
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    n_cmp++;
    if (overrun !== 4'b0 || evt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL t4_clr got=%b/%b exp=0000/1",
               overrun, evt_valid);
    end
    evt_ready = 1'b1;
    for (int n = 37; n <= 45; n++) begin
      step();
      e_v = (n == 42);
      n_cmp++;
      if (evt_valid !== e_v || overrun !== 4'b0) begin
        n_err++;
        $display("FAIL t4_drain cyc=%0d got=%b/%b exp=%b/0000",
                 cyc, evt_valid, overrun, e_v);
      end
    end
  endtask

  task automatic test_disable_offered;
    do_reset();
    wr_cfg(2'd0, 8'd1);
    for (int n = 2; n <= 14; n++) begin
      step();
      e_v = (n >= 12);
      n_cmp++;
      if (evt_valid !== e_v || (e_v && evt_ch !== 2'd0)) begin
        n_err++;
        $display("FAIL t5_pre cyc=%0d got=%b/%0d exp=%b/0",
                 cyc, evt_valid, evt_ch, e_v);
      end
    end
    wr_cfg(2'd0, 8'd0);
    for (int n = 15; n <= 19; n++) begin
      if (n > 15) step();
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
        n_err++;
        $display("FAIL t5_keep cyc=%0d got=%b/%0d exp=1/0",
                 cyc, evt_valid, evt_ch);
      end
    end
    evt_ready = 1'b1;
    for (int n = 20; n <= 50; n++) begin
      step();
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL t5_after cyc=%0d got=%b exp=0",
                 cyc, evt_valid);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    wr_cfg(2'd1, 8'd1);
    for (int n = 2; n <= 30; n++) step();
    n_cmp++;
    if ({base_tick, evt_valid, evt_ch, overrun} !== 8'b1_1_01_0010) begin
      n_err++;
      $display("FAIL t6_pre got=%b/%b/%0d/%b exp=1/1/1/0010",
               base_tick, evt_valid, evt_ch, overrun);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({base_tick, evt_valid, evt_ch, overrun} !== 8'h00) begin
      n_err++;
      $display("FAIL t6_async got=%b/%b/%0d/%b exp=0/0/0/0000",
               base_tick, evt_valid, evt_ch, overrun);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    evt_ready = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      step();
      e_bt = (n % 10 == 0);
      n_cmp++;
      if (evt_valid !== 1'b0 || overrun !== 4'b0 ||
          base_tick !== e_bt) begin
        n_err++;
        $display("FAIL t6_post cyc=%0d got=%b/%b/%b exp=0/0000/%b",
                 cyc, evt_valid, overrun, base_tick, e_bt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_period3();
    test_round_robin();
    test_overrun();
    test_disable_offered();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
